// File: rtl/guess_game_core_if.sv
// guess_game_core_if: game control inputs and display outputs of guess_game_core.
// The master side drives start/next/keypad; the slave side is the game core.
interface guess_game_core_if #(parameter int VAL_W = 4);
    logic             i_start;
    logic             i_next;
    logic [4:0]       i_key_state;
    logic [VAL_W-1:0] o_sys_val;
    logic [VAL_W-1:0] o_guess_val;
    logic [VAL_W-1:0] o_sys_at_guess;
    logic [2:0]       o_result;
    logic [7:0]       o_score;
    logic [3:0]       o_round;
    logic             o_game_over;
    modport master (
        output i_start, i_next, i_key_state,
        input  o_sys_val, o_guess_val, o_sys_at_guess, o_result, o_score, o_round, o_game_over
    );
    modport slave (
        input  i_start, i_next, i_key_state,
        output o_sys_val, o_guess_val, o_sys_at_guess, o_result, o_score, o_round, o_game_over
    );
endinterface

// File: rtl/guess_game_core.sv
// guess_game_core: reaction guessing game -- rotating system value, keypad capture, hit/miss scoring over ROUNDS.
// Define GUESS_LFSR_EN to step sys_val with a maximal-length LFSR (seed all-ones) instead of a plain counter.
module guess_game_core #(
    parameter int VAL_W    = 4,
    parameter int TICK_DIV = 25000,
    parameter int ROUNDS   = 8
) (
    input  logic             clock_100Mhz,
    input  logic             reset,
    guess_game_core_if.slave bus
);
    localparam int         TW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [4:0] NO_KEY = 5'b10000;
`ifdef GUESS_LFSR_EN
    localparam logic [VAL_W-1:0] SEED = '1;
`else
    localparam logic [VAL_W-1:0] SEED = '0;
`endif

    typedef enum logic [1:0] {IDLE, ARMED, SHOW, DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic [TW-1:0]    r_tick;
    logic [VAL_W-1:0] r_sys, w_sys_step;
    logic [VAL_W-1:0] r_guess, w_guess_nxt;
    logic [VAL_W-1:0] r_sat, w_sat_nxt;
    logic [2:0]       r_result, w_result_nxt;
    logic [7:0]       r_score, w_score_nxt;
    logic [3:0]       r_round, w_round_nxt;
    logic             w_tick_end, w_key_ok, w_key_none, w_hit;

    assign w_tick_end = r_tick == TW'(TICK_DIV - 1);
    assign w_key_none = bus.i_key_state == NO_KEY;
    assign w_key_ok   = !w_key_none && ({1'b0, bus.i_key_state[3:0]} < 5'(1 << VAL_W));
    assign w_hit      = bus.i_key_state[VAL_W-1:0] == r_sys;

`ifdef GUESS_LFSR_EN
    logic [3:0] w_lfsr_pad;
    assign w_lfsr_pad = 4'(r_sys);
    // Fibonacci taps (n, n-1) are maximal for widths 2..4; a 1-bit LFSR just holds its seed
    assign w_sys_step = (VAL_W == 1) ? r_sys :
                        VAL_W'({w_lfsr_pad, w_lfsr_pad[VAL_W-1] ^ w_lfsr_pad[(VAL_W > 1) ? VAL_W-2 : 0]});
`else
    assign w_sys_step = r_sys + VAL_W'(1);
`endif

    always_ff @(posedge clock_100Mhz) begin
        if (reset || !bus.i_start) begin
            r_tick <= '0;
            r_sys  <= SEED;
        end else begin
            r_tick <= w_tick_end ? '0 : r_tick + TW'(1);
            if (w_tick_end) r_sys <= w_sys_step;
        end
    end

    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            r_state  <= IDLE;
            r_guess  <= '0;
            r_sat    <= '0;
            r_result <= 3'b001;
            r_score  <= '0;
            r_round  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_guess  <= w_guess_nxt;
            r_sat    <= w_sat_nxt;
            r_result <= w_result_nxt;
            r_score  <= w_score_nxt;
            r_round  <= w_round_nxt;
        end
    end

    // Capture compares against the registered sys_val, i.e. the pre-increment value on a tick edge
    always_comb begin
        w_state_nxt  = r_state;
        w_guess_nxt  = r_guess;
        w_sat_nxt    = r_sat;
        w_result_nxt = r_result;
        w_score_nxt  = r_score;
        w_round_nxt  = r_round;
        if (!bus.i_start) begin
            w_state_nxt  = IDLE;
            w_guess_nxt  = '0;
            w_sat_nxt    = '0;
            w_result_nxt = 3'b001;
            w_score_nxt  = '0;
            w_round_nxt  = '0;
        end else begin
            case (r_state)
                IDLE: w_state_nxt = ARMED;
                ARMED: if (w_key_ok) begin
                    w_state_nxt  = SHOW;
                    w_guess_nxt  = bus.i_key_state[VAL_W-1:0];
                    w_sat_nxt    = r_sys;
                    w_result_nxt = w_hit ? 3'b010 : 3'b100;
                    w_score_nxt  = (w_hit && r_score != 8'hFF) ? r_score + 8'd1 : r_score;
                end
                SHOW: if (bus.i_next && w_key_none) begin
                    if (r_round < 4'(ROUNDS - 1)) begin
                        w_state_nxt  = ARMED;
                        w_round_nxt  = r_round + 4'd1;
                        w_result_nxt = 3'b001;
                        w_guess_nxt  = '0;
                        w_sat_nxt    = '0;
                    end else begin
                        w_state_nxt = DONE;
                    end
                end
                DONE: w_state_nxt = DONE;
            endcase
        end
    end

    assign bus.o_sys_val      = r_sys;
    assign bus.o_guess_val    = r_guess;
    assign bus.o_sys_at_guess = r_sat;
    assign bus.o_result       = r_result;
    assign bus.o_score        = r_score;
    assign bus.o_round        = r_round;
    assign bus.o_game_over    = r_state == DONE;
endmodule
